rx_buf_sched: RTL
=================

// Module: rx_buf_sched
// PURPOSE
//  Round-robin scheduler for NUM_CH receive-buffer channels, each with its own GTP lane, sharing one downstream 64-bit read path.
//  Picks a channel with a full buffer, pulses its send_start, and issues paced reads for ch_len words.
//  Muxes the read data out with SOF/EOF/channel tags, then pulses ch_release so the channel can reuse the buffer.
//  Sits between the per-lane receive kernels and the host/DDR writer; all in the ap_clk domain.
// PARAMETERS
//  NUM_CH      4     number of receive channels (2..8)
//  LEN_W       16    width of per-channel length, in 64-bit words
//  RD_LAT      1     cycles from ch_rd_en to valid ch_rd_data (1..3)
//  TIMEOUT_CYC 1024  stall limit in ap_clk cycles (used only with RX_SCHED_TIMEOUT_EN)
// PORTS
//  ap_clk      in   1            system clock; single clock domain
//  ap_rst      in   1            synchronous, active-high reset
//  ch_ready    in   NUM_CH       level: channel buffer holds a complete frame
//  ch_len      in   NUM_CH*LEN_W words to read; sampled in ARB
//  ch_start    out  NUM_CH       one-hot 1-cycle pulse: start read-out (send_start)
//  ch_rd_en    out  NUM_CH       one-hot read strobe to the granted channel
//  ch_rd_data  in   NUM_CH*64    channel read data, valid RD_LAT after rd_en
//  ch_release  out  NUM_CH       one-hot 1-cycle pulse: buffer consumed
//  dn_ready    in   1            downstream can accept; must absorb RD_LAT beats after deassert
//  dn_valid    out  1            downstream beat valid
//  dn_data     out  64           beat data
//  dn_ch       out  $clog2(NUM_CH) source channel of beat
//  dn_sof      out  1            first beat of frame
//  dn_eof      out  1            last beat of frame
//  busy        out  1            FSM not IDLE
//  err_len0    out  1            1-cycle pulse: granted channel had ch_len==0
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, rr pointer=0 (channel 0 highest priority first), counters 0.
//  Reset mid-transfer aborts silently: no release pulse and no EOF; in-flight read data is discarded.
//  FSM: IDLE->ARB when |ch_ready.
//  ARB: grant the first ready channel at or after rr_ptr; latch grant and len; rr_ptr<=grant+1 (mod NUM_CH). ->START.
//  START: ch_start[grant]=1 for one cycle. len==0 -> err_len0 pulse, ->REL; else ->XFER.
//  XFER: ch_rd_en[grant]=dn_ready && remaining!=0; remaining decrements per rd_en.
//  XFER exit: remaining hits 0 -> DRAIN.
//  DRAIN: wait until the RD_LAT shift pipe holds no beats. ->REL.
//  REL: ch_release[grant]=1 for one cycle. ->IDLE, so ch_ready is re-evaluated 1 cycle later (no double grant).
//  Data pipe: rd_en delayed RD_LAT cycles gives dn_valid; dn_data=ch_rd_data[grant].
//  dn_sof marks the beat of the first rd_en; dn_eof marks the beat of the rd_en issued at remaining==1.
//  len==1 gives SOF and EOF on the same beat.
//  Latency: ARB->first dn_valid is at least 2+RD_LAT cycles; no bubbles while dn_ready stays high.
//  ch_ready dropping after grant is ignored; the transfer completes as latched.
//  Arithmetic: remaining is LEN_W bits and never wraps. Len 2^LEN_W-1 is legal.
// CONFIGURATION
//  RX_SCHED_TIMEOUT_EN defined:
//   - stall counter in XFER counts cycles with dn_ready=0 and resets on any rd_en.
//   - at TIMEOUT_CYC: stop reads, wait DRAIN, then pulse ch_release and output dn_abort (1-cycle pulse).
//   - the aborted frame carries no EOF.
//  RX_SCHED_TIMEOUT_EN undefined: no counter and no dn_abort port; XFER waits indefinitely.
// STRUCTURE
//  Package rx_sched_pkg: FSM state enum {IDLE,ARB,START,XFER,DRAIN,REL}, DATA_W=64, default widths.
//  Sub-module rx_rr_arb: combinational round-robin pick(req, ptr) -> one-hot grant + index.
//  Top holds the FSM, counters, RD_LAT pipe and data mux.
// TESTING
//  1. ch_ready=4'b0001, len0=4, dn_ready=1:
//     one ch_start[0]; 4 beats, SOF on beat 1, EOF on beat 4, dn_ch=0; then ch_release[0].
//  2. ch_ready=4'b1111 held, all len=2:
//     grant order 0,1,2,3,0; each channel gets 2 beats; no gaps beyond FSM overhead.
//  3. len=3, dn_ready toggled 1,0,1,0:
//     exactly 3 rd_en and 3 dn_valid; data order preserved; EOF on 3rd beat.
//  4. len=0 on ch2: err_len0 pulse, ch_release[2], zero dn_valid.
//     len=1 on ch1: single beat with SOF=EOF=1.
//  5. ap_rst asserted in XFER after 2 of 8 beats:
//     next cycle all outputs 0, no release; after reset, ch0 is granted first.
//  6. RX_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, dn_ready=0 for 16 cycles mid-frame:
//     dn_abort and ch_release pulse; FSM returns to IDLE.

Source files
------------

// File: rtl/rx_sched_pkg.sv
// rx_sched_pkg: shared types, widths and helpers for the receive-buffer scheduler
package rx_sched_pkg;
  localparam int DATA_W = 64;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_LEN_W = 16;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_TIMEOUT_CYC = 1024;
  typedef enum logic [2:0] {IDLE, ARB, START, XFER, DRAIN, REL} state_t;
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rx_rr_arb.sv
// rx_rr_arb: combinational round-robin pick of the first request at or after ptr
module rx_rr_arb #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [2*N-1:0] rot;
  int s;
  assign any = |req;
  // rotate requests so bit 0 is ptr; scanning downward leaves the nearest request as winner
  always_comb begin
    rot = {req, req} >> ptr;
    s = 0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) s = int'(ptr) + i - ((int'(ptr) + i >= N) ? N : 0);
    idx = s[PW-1:0];
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/rx_buf_sched.sv
// rx_buf_sched: round-robin read-out of full receive buffers onto one 64-bit stream (optional RX_SCHED_TIMEOUT_EN stall abort)
module rx_buf_sched
  import rx_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [NUM_CH-1:0]          ch_ready,
  input  logic [NUM_CH*LEN_W-1:0]    ch_len,
  output logic [NUM_CH-1:0]          ch_start,
  output logic [NUM_CH-1:0]          ch_rd_en,
  input  logic [NUM_CH*DATA_W-1:0]   ch_rd_data,
  output logic [NUM_CH-1:0]          ch_release,
  input  logic                       dn_ready,
  output logic                       dn_valid,
  output logic [DATA_W-1:0]          dn_data,
  output logic [$clog2(NUM_CH)-1:0]  dn_ch,
  output logic                       dn_sof,
  output logic                       dn_eof,
  output logic                       busy,
`ifdef RX_SCHED_TIMEOUT_EN
  output logic                       dn_abort,
`endif
  output logic                       err_len0
);
  localparam int CW = $clog2(NUM_CH);
  state_t state, state_nx;
  logic [CW-1:0] rr_ptr, grant, arb_idx;
  logic [NUM_CH-1:0] grant_oh, arb_gnt;
  logic arb_any, rd, pipe_busy, sof_pend, timeout;
  logic [LEN_W-1:0] remaining;
  logic [2:0] pipe [RD_LAT];
  rx_rr_arb #(.N(NUM_CH)) u_arb (
    .req(ch_ready),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );
  assign rd = state == XFER && dn_ready && remaining != '0;
`ifdef RX_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] stall;
  logic aborted;
  assign timeout = state == XFER && !dn_ready && stall == TW'(TIMEOUT_CYC - 1);
  assign dn_abort = state == REL && aborted;
  // count consecutive stalled XFER cycles; remember whether the frame was cut short
  always_ff @(posedge ap_clk) begin
    stall <= (ap_rst || state != XFER || rd) ? '0 : stall + 1'b1;
    aborted <= (ap_rst || state == ARB) ? 1'b0 : (timeout ? 1'b1 : aborted);
  end
`else
  assign timeout = 1'b0;
`endif
  // any beat still travelling through the read-latency pipe
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) pipe_busy = pipe_busy | pipe[i][2];
  end
  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |ch_ready ? ARB : IDLE;
      ARB:     state_nx = arb_any ? START : IDLE;
      START:   state_nx = remaining == '0 ? REL : XFER;
      XFER:    state_nx = ((rd && remaining == LEN_W'(1)) || timeout) ? DRAIN : XFER;
      DRAIN:   state_nx = pipe_busy ? DRAIN : REL;
      REL:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state, grant latch, word counter and the {valid,sof,eof} latency pipe
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      grant_oh <= '0;
      remaining <= '0;
      sof_pend <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == ARB && arb_any) begin
        grant <= arb_idx;
        grant_oh <= arb_gnt;
        remaining <= ch_len[arb_idx*LEN_W +: LEN_W];
        rr_ptr <= CW'(rr_next(int'(arb_idx), NUM_CH));
        sof_pend <= 1'b1;
      end else if (rd) begin
        remaining <= remaining - 1'b1;
        sof_pend <= 1'b0;
      end
      pipe[0] <= {rd, rd && sof_pend, rd && remaining == LEN_W'(1)};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign ch_start = state == START ? grant_oh : '0;
  assign ch_rd_en = rd ? grant_oh : '0;
  assign ch_release = state == REL ? grant_oh : '0;
  assign err_len0 = state == START && remaining == '0;
  assign busy = state != IDLE;
  assign dn_valid = pipe[RD_LAT-1][2];
  assign dn_sof = pipe[RD_LAT-1][1];
  assign dn_eof = pipe[RD_LAT-1][0];
  assign dn_ch = dn_valid ? grant : '0;
  assign dn_data = dn_valid ? ch_rd_data[grant*DATA_W +: DATA_W] : '0;
endmodule
